// File: rtl/kpscan_if.sv
// Key-event handshake between the keypad scanner (master) and its consumer (slave).
interface kpscan_if #(parameter int CW = 4);
  logic [CW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;

  modport master (output key_code, key_valid, input key_ready);
  modport slave  (input key_code, key_valid, output key_ready);
endinterface

// File: rtl/kpscan.sv
// Keypad column scanner: rotating active-low column drive, press/release debounce,
// single-entry event buffer. Auto-repeat is built only when KPSCAN_REPEAT_EN is defined.
module kpscan #(
  parameter int NROWS      = 4,
  parameter int NCOLS      = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 8,
  parameter int REPEAT_DLY = 64,
  parameter int REPEAT_PER = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NROWS-1:0] kpr,
  output logic [NCOLS-1:0] kpc,
  output logic             kphit,
  output logic             overrun,
  kpscan_if.master         ev
);
  localparam int CW   = $clog2(NROWS*NCOLS);
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int COLW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int ROWW = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int CNTW = $clog2(DEBOUNCE+1);

  if (SCAN_DIV < 2 || DEBOUNCE < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
    $error("kpscan: parameter out of range");
  end

  typedef enum logic [1:0] {SCAN, DEB_P, PRESSED, DEB_R} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q;
  logic [COLW-1:0]  col_q, col_d, col_nxt;
  logic [ROWW-1:0]  row_q, row_d, srow;
  logic [CNTW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [NROWS-1:0] low;
  logic [CW-1:0]    code;
  logic             tick, single, none, hit_d, confirm, held_tick, rep_fire, fire;

  function automatic logic one_low(input logic [NROWS-1:0] l);
    return $countones(l) == 1;
  endfunction

  function automatic logic [ROWW-1:0] row_of(input logic [NROWS-1:0] l);
    row_of = '0;
    for (int i = 0; i < NROWS; i++)
      if (l[i]) row_of = ROWW'(i);
  endfunction

  assign tick    = (div_q == DW'(SCAN_DIV-1));
  assign low     = ~kpr;
  assign none    = (low == '0);
  assign single  = one_low(low);
  assign srow    = row_of(low);
  assign col_nxt = (col_q == COLW'(NCOLS-1)) ? '0 : col_q + COLW'(1);
  assign cnt_inc = cnt_q + CNTW'(1);
  assign fire    = confirm | rep_fire;
  assign code    = CW'(row_d) * CW'(NCOLS) + CW'(col_q);

  // Column is held from first detection until the release is confirmed.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    hit_d     = kphit;
    confirm   = 1'b0;
    held_tick = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (single) begin
            row_d = srow;
            cnt_d = CNTW'(1);
            if (DEBOUNCE == 1) begin
              state_d = PRESSED;
              hit_d   = 1'b1;
              confirm = 1'b1;
            end else begin
              state_d = DEB_P;
            end
          end else begin
            col_d = col_nxt;
          end
        end
        DEB_P: begin
          if (single && srow == row_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNTW'(DEBOUNCE)) begin
              state_d = PRESSED;
              hit_d   = 1'b1;
              confirm = 1'b1;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_nxt;
          end
        end
        PRESSED: begin
          if (none) begin
            cnt_d = CNTW'(1);
            if (DEBOUNCE == 1) begin
              state_d = SCAN;
              hit_d   = 1'b0;
              col_d   = col_nxt;
            end else begin
              state_d = DEB_R;
            end
          end else begin
            held_tick = 1'b1;
          end
        end
        DEB_R: begin
          if (!kpr[row_q]) begin
            state_d = PRESSED;
          end else if (none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNTW'(DEBOUNCE)) begin
              state_d = SCAN;
              hit_d   = 1'b0;
              col_d   = col_nxt;
            end
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      div_q   <= '0;
      col_q   <= '0;
      kpc     <= ~NCOLS'(1);
      row_q   <= '0;
      cnt_q   <= '0;
      kphit   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= tick ? '0 : div_q + DW'(1);
      col_q   <= col_d;
      kpc     <= ~(NCOLS'(1) << col_d);
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      kphit   <= hit_d;
    end
  end

`ifdef KPSCAN_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX+1);

  logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;
  logic          rarm_q, rarm_d;

  assign rcnt_inc = rcnt_q + RW'(1);

  // First repeat after REPEAT_DLY held ticks, then every REPEAT_PER ticks.
  always_comb begin
    rcnt_d   = rcnt_q;
    rarm_d   = rarm_q;
    rep_fire = 1'b0;
    if (confirm) begin
      rcnt_d = '0;
      rarm_d = 1'b0;
    end else if (held_tick) begin
      if (rcnt_inc == (rarm_q ? RW'(REPEAT_PER) : RW'(REPEAT_DLY))) begin
        rep_fire = 1'b1;
        rcnt_d   = '0;
        rarm_d   = 1'b1;
      end else begin
        rcnt_d = rcnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q <= '0;
      rarm_q <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rarm_q <= rarm_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // A new event may replace one that is being accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev.key_code  <= '0;
      ev.key_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (fire) begin
        if (!ev.key_valid || ev.key_ready) begin
          ev.key_code  <= code;
          ev.key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ev.key_ready) begin
        ev.key_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/kpscan.md
# kpscan

Parametrised keypad scanner and event generator for the Simon keypad path. It drives active-low column selects in rotation and samples active-low row inputs with pull-ups. Each key is debounced on press and release, and a single key-code event per press is delivered on a valid/ready handshake. It supersedes the purely combinational row/column decode: column driving, debouncing, multi-key rejection and event buffering move into this block, and the game FSM consumes `key_code` directly.

## Interface
- `NROWS`, 4: number of keypad rows.
- `NCOLS`, 4: number of keypad columns.
- `SCAN_DIV`, 1000: clocks per column dwell; one sample tick per dwell, ≥2.
- `DEBOUNCE`, 8: consecutive stable sample ticks needed to confirm a press or a release, ≥1.
- `REPEAT_DLY`, 64: ticks held before the first repeat (only with `KPSCAN_REPEAT_EN`).
- `REPEAT_PER`, 16: ticks between repeats (only with `KPSCAN_REPEAT_EN`).
- `CW`, $clog2(NROWS*NCOLS): key-code width, derived, not overridable.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `kpr` in NROWS: row inputs, active-low.
- `kpc` out NCOLS: column select, active-low one-hot.
- `key_code` out CW: event code = row*NCOLS + col.
- `key_valid` out 1: event available.
- `key_ready` in 1: consumer accepts the event.
- `kphit` out 1: debounced key-held level.
- `overrun` out 1: one-cycle pulse when an event is dropped.

## Operation
- Reset values: `kpc` = all ones except bit 0 low; `key_code`=0; `key_valid`=0; `kphit`=0; `overrun`=0. Divider = 0, state = SCAN.
- Divider: counts 0..SCAN_DIV-1 and wraps. A tick occurs on the cycle the divider equals SCAN_DIV-1. Rows are sampled only on ticks.
- A sample is **single** when exactly one `kpr` bit is low. It is **none** when all bits are high. Any other pattern is **multi**.
- SCAN
  - On a tick with a single sample: go to DEB_P. Capture candidate (row, current col). Count = 1. The column is held.
  - On a tick with none or multi: advance to column (col+1) mod NCOLS. `kpc` updates the cycle after the tick.
- DEB_P
  - Tick with the same single row: count++.
  - When count reaches DEBOUNCE: go to PRESSED, set `kphit`=1, issue an event.
  - Tick with any other sample: return to SCAN and advance the column.
- PRESSED
  - Column held.
  - Tick with a none sample: go to DEB_R, count = 1.
  - Multi or a different row: ignored, stay in PRESSED.
- DEB_R
  - Tick with a none sample: count++.
  - When count reaches DEBOUNCE: `kphit`=0, go to SCAN, advance the column.
  - Tick with the original row low: return to PRESSED, no new event.
- Event issue:
  - If `key_valid`=0, or `key_valid`=1 and `key_ready`=1 in the same cycle: `key_code` is loaded and `key_valid`=1 the next cycle.
  - Otherwise the event is dropped and `overrun` pulses for one cycle.
- Handshake:
  - Transfer happens on a cycle where `key_valid` and `key_ready` are both 1. `key_valid` falls the next cycle unless a new event loads simultaneously.
  - `key_code` is stable while `key_valid`=1.
  - `key_ready` is ignored while `key_valid`=0.
- Reset mid-operation: any pending event is discarded and all state returns to reset values. No `overrun` pulse is generated.

## Timing
- `kpc` is registered and changes only the cycle after a tick.
- Press latency: `key_valid` rises 1 cycle after the tick that completes DEBOUNCE, i.e. DEBOUNCE ticks after first detection.
- Worst-case detection latency is NCOLS·SCAN_DIV clocks plus the debounce time.
- `kphit` rises in the same cycle as `key_valid` for a fresh event and falls 1 cycle after the release-confirming tick.
- Sequential presses: minimum 2·DEBOUNCE ticks between events.

## Configuration
- `KPSCAN_REPEAT_EN` defined:
  - In PRESSED, the block counts ticks held.
  - At REPEAT_DLY ticks it issues a repeat event with the same code, then one every REPEAT_PER ticks.
  - Repeat events follow the same handshake and overrun rules.
  - The repeat counter clears on entry to PRESSED from DEB_P and does not clear on a return from DEB_R.
- `KPSCAN_REPEAT_EN` not defined: exactly one event per press. The repeat counter and the REPEAT parameters are absent from the hardware.

## Test plan
All scenarios use NROWS=4, NCOLS=4, SCAN_DIV=4, DEBOUNCE=3 unless stated.
- Reset: after reset, `kpc`=4'b1110 and all outputs are 0. `kpc` steps 1101, 1011, 0111, 1110 every 4 clocks with no key pressed.
- Single press: hold row 1 low whenever column 2 is driven. Required: exactly one event with `key_code`=6 and `kphit`=1 after 3 ticks, `key_ready`=1. On release, `kphit` falls after 3 ticks.
- Bounce: row toggles every tick during DEB_P. Required: no event, and scanning continues.
- Multi-key: rows 0 and 2 low on column 1. Required: no event, and the column keeps advancing.
- Overrun: `key_ready`=0. Press and release key code 6, then press key code 13 (row 3, column 1). Required: `key_code` stays 6 and `overrun` pulses once. Raising `key_ready` completes the transfer and `key_valid` falls.
- Repeat, with `KPSCAN_REPEAT_EN` defined and REPEAT_DLY=5, REPEAT_PER=2: hold key code 6 for 12 ticks with `key_ready`=1. Required: events at confirm, confirm+5, confirm+7, confirm+9 and confirm+11 ticks.
